// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed 7-segment scanner sharing one decoder.
// Double-buffered display value, applied only at frame start.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic                    lz_suppress,
  output logic [3:0]              hex_nibble,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ?
                        DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DLAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] DMAX  = DW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] digit_q, digit_d;
  logic copy;

  logic [VW-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_mask_q, act_mask_d;
  logic [VW-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d;
  logic ready_q, ready_d;
  logic load_fire;

  logic [3:0] hex_q, hex_d;
  logic [6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic fd_q, fd_d;

  logic [NUM_DIGITS-1:0] blank_vec;
  logic [3:0] next_nib;

  // Scan sequencing: BLANK then DRIVE per digit; copy pending at frame wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    copy    = 1'b0;
    unique case (state_q)
      S_BLANK: begin
        if (cnt_q == BLAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == DLAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          digit_d = (digit_q == DMAX) ? '0 : digit_q + 1'b1;
          copy    = (digit_q == DMAX) & ~ready_q;
        end
      end
      default: ;
    endcase
  end

  // Per-digit blanking: forced mask or leading zero (digit 0 always shown).
  always_comb begin
    logic zero_up;
    zero_up   = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_up = zero_up & (act_val_q[4*i +: 4] == 4'h0);
      blank_vec[i] = act_mask_q[i] |
                     (lz_suppress & (i != 0) & zero_up);
    end
  end

  // Nibble for the digit about to be scanned, taken from the post-copy value.
  always_comb begin
    next_nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_d == DW'(i)) next_nib = act_val_d[4*i +: 4];
    end
  end

  // Load handshake, buffer copy and registered output next-state.
  always_comb begin
    load_fire   = load_valid & ready_q;
    act_val_d   = copy ? pend_val_q : act_val_q;
    act_mask_d  = copy ? pend_mask_q : act_mask_q;
    pend_val_d  = load_fire ? load_value : pend_val_q;
    pend_mask_d = load_fire ? load_blank : pend_mask_q;

    ready_d = ready_q;
    if (load_fire)  ready_d = 1'b0;
    else if (copy)  ready_d = 1'b1;

    hex_d = hex_q;
    if (state_q == S_DRIVE && state_d == S_BLANK) hex_d = next_nib;

    seg_d = seg_q;
    if (state_q == S_BLANK && cnt_q == BLAST)
      seg_d = blank_vec[digit_q] ? 7'h7F : seg_in;

    en_d = '1;
    if (state_d == S_DRIVE && !blank_vec[digit_d]) en_d[digit_d] = 1'b0;

    fd_d = (state_d == S_DRIVE) && (digit_d == DMAX) && (cnt_d == DLAST);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_BLANK;
      cnt_q       <= '0;
      digit_q     <= '0;
      act_val_q   <= '0;
      act_mask_q  <= '0;
      pend_val_q  <= '0;
      pend_mask_q <= '0;
      ready_q     <= 1'b1;
      hex_q       <= 4'h0;
      seg_q       <= 7'h7F;
      en_q        <= '1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      act_val_q   <= act_val_d;
      act_mask_q  <= act_mask_d;
      pend_val_q  <= pend_val_d;
      pend_mask_q <= pend_mask_d;
      ready_q     <= ready_d;
      hex_q       <= hex_d;
      seg_q       <= seg_d;
      en_q        <= en_d;
      fd_q        <= fd_d;
    end
  end

  assign load_ready = ready_q;
  assign hex_nibble = hex_q;
  assign seg_out    = seg_q;
  assign digit_en_n = en_q;
  assign frame_done = fd_q;

endmodule
